// File: rtl/sqrt_sequencer_if.sv
// Control/status bundle between the square-root sequencer and its requester/datapath.
// The requester drives start/operand, and the datapath returns the ALU negative flag.
interface sqrt_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [DATA_WIDTH-1:0] operand_i;
  logic                  negative_i;
  logic [DATA_WIDTH-1:0] op_data_o;
  logic                  IE;
  logic                  WE;
  logic                  OE;
  logic [2:0]            ADDR_WR;
  logic [2:0]            ADDR_RDA;
  logic [2:0]            ADDR_RDB;
  logic [1:0]            ALU_Op;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;

  modport master (
    output start_i, operand_i, negative_i,
    input  op_data_o, IE, WE, OE, ADDR_WR, ADDR_RDA, ADDR_RDB, ALU_Op,
    input  busy_o, done_o, error_o
  );

  modport slave (
    input  start_i, operand_i, negative_i,
    output op_data_o, IE, WE, OE, ADDR_WR, ADDR_RDA, ADDR_RDB, ALU_Op,
    output busy_o, done_o, error_o
  );
endinterface

// File: rtl/sqrt_sequencer.sv
// Sequences floor(sqrt(x)) by odd-number subtraction on an external register-file/ALU
// datapath; the count of successful subtractions is passed to the datapath output register.
module sqrt_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_ITER   = 46341
) (
  input  logic            clk,
  input  logic            rst_n,
  sqrt_sequencer_if.slave bus
);

  localparam int               CNT_W      = $clog2(MAX_ITER + 1);
  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_PASS_A = 2'b11;

  localparam logic [2:0] R_X   = 3'd0;
  localparam logic [2:0] R_ODD = 3'd1;
  localparam logic [2:0] R_CNT = 3'd2;
  localparam logic [2:0] R_K1  = 3'd3;
  localparam logic [2:0] R_K2  = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_LD_X, S_LD_ODD, S_LD_CNT, S_LD_K1, S_LD_K2,
    S_SUB, S_INC_CNT, S_INC_ODD, S_OUT, S_DONE, S_ERR
  } state_t;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  ie;
    logic                  we;
    logic                  oe;
    logic [1:0]            alu;
    logic [2:0]            wr;
    logic [2:0]            rda;
    logic [2:0]            rdb;
    logic [DATA_WIDTH-1:0] data;
  } ctrl_t;

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] iter_cnt;
  logic             at_limit;

  assign at_limit = (iter_cnt == ITER_LIMIT);

  function automatic state_t next_of(state_t s, logic start, logic op_msb,
                                     logic neg, logic lim);
    state_t n;
    n = s;
    case (s)
      S_IDLE:    if (start) n = op_msb ? S_ERR : S_LD_X;
      S_LD_X:    n = S_LD_ODD;
      S_LD_ODD:  n = S_LD_CNT;
      S_LD_CNT:  n = S_LD_K1;
      S_LD_K1:   n = S_LD_K2;
      S_LD_K2:   n = S_SUB;
      S_SUB:     n = neg ? S_OUT : (lim ? S_ERR : S_INC_CNT);
      S_INC_CNT: n = S_INC_ODD;
      S_INC_ODD: n = S_SUB;
      S_OUT:     n = S_DONE;
      default:   n = S_IDLE;
    endcase
    return n;
  endfunction

  // Controls are precomputed for the state being entered so they appear registered
  // alongside it; the operand is captured here on the IDLE -> LD_X step.
  function automatic ctrl_t ctrl_for(state_t s, logic [DATA_WIDTH-1:0] operand);
    ctrl_t c;
    c      = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_LD_X:    begin c.ie = 1'b1; c.we = 1'b1; c.wr = R_X;   c.data = operand;           end
      S_LD_ODD:  begin c.ie = 1'b1; c.we = 1'b1; c.wr = R_ODD; c.data = DATA_WIDTH'(1);    end
      S_LD_CNT:  begin c.ie = 1'b1; c.we = 1'b1; c.wr = R_CNT; c.data = '0;                end
      S_LD_K1:   begin c.ie = 1'b1; c.we = 1'b1; c.wr = R_K1;  c.data = DATA_WIDTH'(1);    end
      S_LD_K2:   begin c.ie = 1'b1; c.we = 1'b1; c.wr = R_K2;  c.data = DATA_WIDTH'(2);    end
      S_SUB:     begin c.rda = R_X;   c.rdb = R_ODD; c.alu = ALU_SUB; c.wr = R_X;           end
      S_INC_CNT: begin c.rda = R_CNT; c.rdb = R_K1;  c.alu = ALU_ADD; c.wr = R_CNT; c.we = 1'b1; end
      S_INC_ODD: begin c.rda = R_ODD; c.rdb = R_K2;  c.alu = ALU_ADD; c.wr = R_ODD; c.we = 1'b1; end
      S_OUT:     begin c.rda = R_CNT; c.alu = ALU_PASS_A; c.oe = 1'b1;                      end
      S_DONE:    c.done = 1'b1;
      S_ERR:     c.err  = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

  assign state_nxt = next_of(state, bus.start_i, bus.operand_i[DATA_WIDTH-1],
                             bus.negative_i, at_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ctrl_q   <= '0;
      iter_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= ctrl_for(state_nxt, bus.operand_i);
      if (state == S_LD_X)
        iter_cnt <= '0;
      else if (state == S_INC_CNT)
        iter_cnt <= iter_cnt + CNT_W'(1);
    end
  end

  // The remainder is only overwritten while it stays non-negative and the loop is in budget.
  assign bus.WE        = (state == S_SUB) ? (~bus.negative_i & ~at_limit) : ctrl_q.we;
  assign bus.IE        = ctrl_q.ie;
  assign bus.OE        = ctrl_q.oe;
  assign bus.op_data_o = ctrl_q.data;
  assign bus.ADDR_WR   = ctrl_q.wr;
  assign bus.ADDR_RDA  = ctrl_q.rda;
  assign bus.ADDR_RDB  = ctrl_q.rdb;
  assign bus.ALU_Op    = ctrl_q.alu;
  assign bus.busy_o    = ctrl_q.busy;
  assign bus.done_o    = ctrl_q.done;
  assign bus.error_o   = ctrl_q.err;

endmodule

// File: doc/sqrt_sequencer.md
SQRT_SEQUENCER -- requirements
Module: sqrt_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the operand and of the datapath data bus.
REQ-002 Parameter MAX_ITER, default 46341, loop-count limit before error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  request to compute floor(sqrt(operand_i)); sampled only in IDLE.
REQ-006 operand_i  input  DATA_WIDTH  unsigned operand, sampled with start_i.
REQ-007 negative_i  input  1  datapath ALU negative flag, combinational in the same cycle.
REQ-008 op_data_o  output  DATA_WIDTH  value driven onto the datapath external data input.
REQ-009 IE  output  1  1 selects op_data_o into the register file; 0 selects the ALU result.
REQ-010 WE  output  1  register-file write enable.
REQ-011 OE  output  1  load enable for the datapath output register.
REQ-012 ADDR_WR, ADDR_RDA, ADDR_RDB  output  3 each  register-file write, read-A and read-B addresses.
REQ-013 ALU_Op  output  2  encodings: 00 ADD, 01 SUB, 11 PASS_A (result = A); 10 is not used.
REQ-014 busy_o  output  1  high from the cycle after start is accepted until DONE/ERR is left.
REQ-015 done_o  output  1  one-cycle pulse; the datapath output register holds the result.
REQ-016 error_o  output  1  one-cycle pulse; operation aborted.

Function
REQ-017 Register map: R0 holds the remainder x, R1 the odd term, R2 the count, R3 the constant 1, R4 the constant 2.
REQ-018 FSM states and per-state actions:
- IDLE: all controls 0.
- LD_X: IE=1, WE=1, WR=0, op_data=operand.
- LD_ODD: IE=1, WE=1, WR=1, op_data=1.
- LD_CNT: IE=1, WE=1, WR=2, op_data=0.
- LD_K1: IE=1, WE=1, WR=3, op_data=1.
- LD_K2: IE=1, WE=1, WR=4, op_data=2.
- SUB: RDA=0, RDB=1, ALU=SUB, WR=0, WE = ~negative_i.
- INC_CNT: RDA=2, RDB=3, ALU=ADD, WR=2, WE=1.
- INC_ODD: RDA=1, RDB=4, ALU=ADD, WR=1, WE=1.
- OUT: RDA=2, ALU=PASS_A, OE=1, WE=0.
- DONE: done_o=1.
- ERR: error_o=1.
REQ-019 Transitions:
- IDLE goes to LD_X on start_i with operand_i[DATA_WIDTH-1]=0.
- IDLE goes to ERR on start_i with operand_i[DATA_WIDTH-1]=1.
- The load states run LD_X, LD_ODD, LD_CNT, LD_K1, LD_K2, then SUB.
- SUB goes to OUT if negative_i=1, otherwise to INC_CNT.
- INC_CNT goes to INC_ODD; INC_ODD goes to SUB.
- OUT goes to DONE; DONE and ERR go to IDLE.
REQ-020 An internal iteration counter clears in LD_X and increments in INC_CNT. If SUB is entered with negative_i=0 and the counter equals MAX_ITER, the FSM goes to ERR and WE=0.
REQ-021 For a result s, latency from the start_i sample edge to done_o high is 8+3s cycles.
REQ-022 start_i outside IDLE is ignored and not queued.
REQ-023 operand 0 gives result 0, because the first SUB is negative.
REQ-024 In states where IE=0, op_data_o SHALL be 0; unused addresses SHALL be 0.
REQ-025 busy_o SHALL be 0 in IDLE and 1 in all other states.

Reset
REQ-026 While rst_n=0, the FSM is in IDLE, the iteration counter is 0, and all outputs are 0 (IE, WE, OE, ALU_Op, addresses, op_data_o, busy_o, done_o, error_o).
REQ-027 Reset deasserted mid-operation returns to IDLE with no done_o or error_o pulse; the next start_i is accepted normally.

Verification
REQ-028 operand 0 -> datapath output 0, done_o 8 cycles after start, exactly one pulse.
REQ-029 operand 16 -> output 4 at 20 cycles; operand 15 -> output 3 at 17 cycles; operand 1 -> output 1 at 11 cycles.
REQ-030 operand 0x7FFFFFFF -> output 46340, no error_o.
REQ-031 operand 0x80000000 -> error_o pulse 1 cycle after start, WE never asserted, busy_o high for 1 cycle.
REQ-032 start_i re-asserted with operand 9 while computing 16 -> result 4, second request ignored, single done_o.
REQ-033 rst_n pulsed low during the INC_CNT of operand 100 -> all outputs 0 immediately, no done_o; a subsequent operand 4 gives 2.
